// File: rtl/nand_seq_pkg.sv
// Shared types and constants for the NAND-based XOR/XNOR sequencer.
// Holds the FSM and step encodings plus per-mode step counts.
package nand_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5
    } step_t;

    localparam int STEPS_XNOR = 5;
    localparam int STEPS_XOR  = 6;

    // XNOR finishes at S4; XOR needs the extra inverting step S5
    function automatic step_t last_step(input logic mode);
        if (mode)
            return step_t'(3'(STEPS_XNOR - 1));
        return step_t'(3'(STEPS_XOR - 1));
    endfunction

endpackage

// File: rtl/nand_gate.sv
// Single 2-input NAND evaluator shared by every step of the sequencer.
// Purely combinational.
module nand_gate (
    output logic out,
    input  logic in1,
    input  logic in2
);

    assign out = ~(in1 & in2);

endmodule

// File: rtl/nand_xor_sequencer.sv
// Bit-serial XOR/XNOR built from one shared NAND gate, one NAND per cycle.
// Bits are processed LSB first; result is held between operations.
module nand_xor_sequencer
    import nand_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_t           state;
    state_t           state_n;
    step_t            step;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             mode_q;
    logic             x;
    logic             y;
    logic             w;
    logic             u;
    logic             z;
    logic             a_bit;
    logic             b_bit;
    logic             in1;
    logic             in2;
    logic             nand_out;
    logic             accept;
    logic             bit_end;

    assign a_bit = a_q[idx];
    assign b_bit = b_q[idx];

    always_comb begin
        state_n = state;
        busy    = (state != IDLE);
        done    = (state == DONE);
        accept  = (state == IDLE) && start;
        bit_end = (state == EVAL) && (step == last_step(mode_q));
        unique case (state)
            IDLE: if (start) state_n = EVAL;
            EVAL: if (bit_end && idx == LAST_IDX) state_n = DONE;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Operand mux: each step routes two stored/operand bits into the NAND
    always_comb begin
        in1 = 1'b0;
        in2 = 1'b0;
        unique case (step)
            S0: begin in1 = a_bit; in2 = a_bit; end
            S1: begin in1 = b_bit; in2 = b_bit; end
            S2: begin in1 = y;     in2 = x;     end
            S3: begin in1 = a_bit; in2 = b_bit; end
            S4: begin in1 = w;     in2 = u;     end
            S5: begin in1 = z;     in2 = z;     end
            default: ;
        endcase
    end

    nand_gate u_nand (
        .out (nand_out),
        .in1 (in1),
        .in2 (in2)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            mode_q <= 1'b0;
            result <= '0;
            idx    <= '0;
            step   <= S0;
            x      <= 1'b0;
            y      <= 1'b0;
            w      <= 1'b0;
            u      <= 1'b0;
            z      <= 1'b0;
        end else if (accept) begin
            a_q    <= a;
            b_q    <= b;
            mode_q <= mode;
            result <= '0;
            idx    <= '0;
            step   <= S0;
        end else if (state == EVAL) begin
            unique case (step)
                S0:      x <= nand_out;
                S1:      y <= nand_out;
                S2:      w <= nand_out;
                S3:      u <= nand_out;
                default: z <= nand_out;
            endcase
            if (bit_end) begin
                result[idx] <= nand_out;
                step        <= S0;
                if (idx != LAST_IDX)
                    idx <= idx + IDX_W'(1);
            end else begin
                step <= step_t'(step + 3'd1);
            end
        end
    end

endmodule

// File: tb/tb_nand_xor_sequencer.sv
// Scoreboard bench: driver pushes expected result and done cycle,
// a negedge monitor checks done timing, result, busy and held value.
module tb_nand_xor_sequencer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    typedef struct {
        logic [W-1:0] res;
        int           due;
    } exp_t;

    exp_t         sb[$];
    int           cyc    = 0;
    int           checks = 0;
    int           errors = 0;
    int           blo    = 0;
    int           bhi    = -1;
    logic [W-1:0] hold   = '0;
    bit           armed  = 1'b0;

    nand_xor_sequencer #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .mode   (mode),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] model(input logic [W-1:0] ma,
                                           input logic [W-1:0] mb,
                                           input logic mm);
        return mm ? ~(ma ^ mb) : (ma ^ mb);
    endfunction

    function automatic int steps(input logic mm);
        return mm ? 5 : 6;
    endfunction

    always @(negedge clk) begin
        if (armed) begin
            logic bexp;
            exp_t e;
            bexp = (cyc >= blo) && (cyc <= bhi);
            checks++;
            if (busy !== bexp) begin
                errors++;
                $display("FAIL busy cyc=%0d got %b want %b", cyc, busy, bexp);
            end
            if (!bexp) begin
                checks++;
                if (result !== hold) begin
                    errors++;
                    $display("FAIL hold cyc=%0d got %h want %h",
                             cyc, result, hold);
                end
            end
            if (done === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_done cyc=%0d got 1 want 0", cyc);
                end else begin
                    e = sb.pop_front();
                    if (cyc != e.due) begin
                        errors++;
                        $display("FAIL latency got cyc %0d want cyc %0d",
                                 cyc, e.due);
                    end
                    checks++;
                    if (result !== e.res) begin
                        errors++;
                        $display("FAIL result cyc=%0d got %h want %h",
                                 cyc, result, e.res);
                    end
                    hold = e.res;
                end
            end else if (done !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL done_x cyc=%0d got %b want 0/1", cyc, done);
            end else if (sb.size() != 0 && cyc > sb[0].due) begin
                checks++;
                errors++;
                $display("FAIL missed_done cyc=%0d got none want cyc %0d",
                         cyc, sb[0].due);
                void'(sb.pop_front());
            end
        end
    end

    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic tm);
        exp_t e;
        @(negedge clk);
        #1;
        start = 1'b1;
        a     = ta;
        b     = tb_;
        mode  = tm;
        e.res = model(ta, tb_, tm);
        e.due = cyc + 1 + W * steps(tm);
        sb.push_back(e);
        blo   = cyc + 1;
        bhi   = e.due;
        @(negedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic tm, input bit noisy);
        issue(ta, tb_, tm);
        for (int i = 0; i < 200 && sb.size() != 0; i++) begin
            if (noisy) begin
                start = 1'($urandom_range(0, 1));
                a     = W'($urandom);
                b     = W'($urandom);
                mode  = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            #1;
        end
        // Now in the DONE cycle: a start here must be ignored
        start = noisy ? 1'b1 : 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
    endtask

    task automatic rst_mid(input int k, input logic with_start);
        issue(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
        repeat (k) begin
            @(negedge clk);
            #1;
        end
        rst   = 1'b1;
        start = with_start;
        sb.delete();
        bhi   = cyc;
        hold  = '0;
        @(negedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        mode  = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        #1;
        rst   = 1'b0;
        armed = 1'b1;

        do_op(4'b0101, 4'b0011, 1'b1, 1'b0);
        do_op(4'b0101, 4'b0011, 1'b0, 1'b0);
        do_op(4'b1100, 4'b1010, 1'b0, 1'b0);
        do_op(4'b1100, 4'b1010, 1'b1, 1'b0);
        do_op(4'b0000, 4'b1111, 1'b1, 1'b1);
        do_op(4'b1111, 4'b1111, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++)
            do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b1);
        rst_mid(9, 1'b0);
        do_op(4'b0110, 4'b1011, 1'b0, 1'b0);
        rst_mid(5, 1'b1);
        do_op(4'b1001, 4'b0001, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++)
            do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
        start = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nand_xor_sequencer.md
NAND_XOR_SEQUENCER -- requirements
Module: nand_xor_sequencer

Interface
REQ-001 SHALL have parameter: WIDTH, default 4, operand/result width in bits (legal range 1..16).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: start  input  1  request to begin one operation.
REQ-005 SHALL have port: mode  input  1  0 = XOR, 1 = XNOR; sampled with start.
REQ-006 SHALL have ports: a, b  input  WIDTH  operands; sampled with start.
REQ-007 SHALL have port: busy  output  1  high while an operation is in progress.
REQ-008 SHALL have port: done  output  1  one-cycle pulse when result is final.
REQ-009 SHALL have port: result  output  WIDTH  computed word; held stable outside an operation.

Function
REQ-010 SHALL compute every result bit using only one shared 2-input NAND evaluator, one evaluation per clock cycle.
REQ-011 SHALL use the following per-bit step sequence on operand bits ai, bi:
- S0: x = NAND(ai, ai)
- S1: y = NAND(bi, bi)
- S2: w = NAND(y, x)
- S3: u = NAND(ai, bi)
- S4: z = NAND(w, u), which is XNOR.
- S5 (mode = 0 only): z = NAND(z, z), which is XOR.
REQ-012 SHALL use steps-per-bit S = 5 for XNOR and S = 6 for XOR.
REQ-013 SHALL implement the state machine IDLE -> EVAL -> DONE -> IDLE.
REQ-014 SHALL, in IDLE with start = 1, latch a, b and mode, clear result to 0, set bit index = 0 and step = 0, and go to EVAL.
REQ-015 SHALL, in EVAL, perform one step per cycle, storing the outputs in internal registers x, y, w, u and z.
REQ-016 SHALL, on the final step of a bit, write z into result[bit index]; if bit index = WIDTH-1 it SHALL go to DONE, otherwise it SHALL increment bit index and reset step to 0.
REQ-017 SHALL assert done = 1 for exactly the one cycle spent in DONE, then return to IDLE.
REQ-018 SHALL process bits LSB first.
REQ-019 SHALL drive busy = 1 in EVAL and DONE and busy = 0 in IDLE.
REQ-020 SHALL have latency: with start accepted at edge 0, done is high during cycle WIDTH*S+1.
REQ-021 SHALL ignore start while busy = 1, including in DONE; the latched operands SHALL NOT change mid-operation.
REQ-022 SHALL NOT depend on changes of a, b or mode after acceptance.
REQ-023 SHALL accept start asserted in the first IDLE cycle after DONE, i.e. allow back-to-back operations with a one-cycle IDLE gap.
REQ-024 SHALL keep result unchanged from DONE until the next accepted start.

Reset
REQ-025 SHALL, when rst = 1 at a clock edge, force state = IDLE, busy = 0, done = 0, result = 0, and clear the bit index, step and scratch registers x, y, w, u, z.
REQ-026 SHALL abort any operation in progress on a reset mid-operation, with no done pulse.
REQ-027 SHALL give rst priority over start when both are asserted at the same edge.

Structure
REQ-028 SHALL place the following in the shared package nand_seq_pkg:
- state encoding (IDLE, EVAL, DONE);
- step encodings S0..S5;
- constants STEPS_XNOR = 5 and STEPS_XOR = 6.
REQ-029 SHALL instantiate the existing nand_gate sub-module exactly once, ports in the order (out, in1, in2).
REQ-030 SHALL drive the inputs of that nand_gate instance from a step-indexed operand mux.
REQ-031 SHALL contain no other logic gates in the bit datapath.

Verification
REQ-032 SHALL cover: WIDTH=4, a=0101, b=0011, mode=1, start pulse -> result=1001, done high in cycle 21, busy high in cycles 1..21.
REQ-033 SHALL cover: same operands, mode=0 -> result=0110, done high in cycle 25.
REQ-034 SHALL cover: exhaustive 1-bit pairs (00, 01, 10, 11) in both modes -> XOR 0,1,1,0 and XNOR 1,0,0,1; these match the gate-level NAND network truth table.
REQ-035 SHALL cover: start re-asserted and a, b changed during EVAL -> result unaffected, with exactly one done pulse.
REQ-036 SHALL cover: rst at cycle 10 of an operation -> busy=0 and result=0 next cycle, no done; a following start then completes normally.
REQ-037 SHALL cover: back-to-back start in the IDLE cycle after done -> the second operation completes with the same latency and correct result.
